fp_mult_arbiter: RTL
====================

// Module: fp_mult_arbiter
// PURPOSE
//  Shares one combinational fp_mult instance between N_REQ requesters.
//  Requesters present operand pairs on valid/ready channels; a round-robin arbiter grants one at a time.
//  The block registers the operands, captures the product and status, and returns them tagged with the requester id.
//  The response is held until the consumer accepts it. Sits between multiple datapath clients and the single FP multiplier.
// PARAMETERS
//  N_REQ   4          number of requesters (2..16)
//  round   IEEE_near  round_values rounding mode, passed unchanged to fp_mult
//  ID_W    $clog2(N_REQ)  requester-id width (derived, localparam)
// PORTS
//  clk           in   1          clock, rising edge
//  rst           in   1          asynchronous reset, active-high
//  req_valid     in   N_REQ      per-requester operand valid
//  req_ready     out  N_REQ      per-requester grant; one-hot or zero
//  req_a         in   N_REQ x32  per-requester operand a, IEEE-754 single
//  req_b         in   N_REQ x32  per-requester operand b, IEEE-754 single
//  resp_valid    out  1          result available
//  resp_ready    in   1          consumer accepts result
//  resp_id       out  ID_W       index of the requester that issued this result
//  resp_z        out  32         product a*b
//  resp_status   out  8          fp_mult status flags for this product
//  busy          out  1          high whenever state != IDLE
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, rr_ptr=0, operand/id/result regs=0, resp_valid=0, busy=0, req_ready=0.
//  FSM:
//   IDLE: req_ready = rr-grant(req_valid, rr_ptr), purely combinational, at most one bit set.
//         If any req_valid, at the edge capture a/b/id of winner w -> CALC; rr_ptr <= (w+1) mod N_REQ.
//         If no req_valid: stay in IDLE, rr_ptr unchanged.
//   CALC: fp_mult sees the registered operands. At the edge capture z/status -> RESP. Unconditional, 1 cycle.
//   RESP: resp_valid=1; resp_id/z/status stable. resp_ready=1 -> IDLE at the edge; else hold.
//  req_ready is 0 in CALC and RESP. No new grant is issued in the cycle a response is accepted.
//  Latency: accept at edge T -> resp_valid high in cycle T+2. Throughput: 1 per 3 cycles at best.
//  Round robin: search starts at rr_ptr, ascending with wrap N_REQ-1 -> 0.
//   A continuously requesting client waits at most N_REQ-1 grants.
//  Requester rule: once req_valid is high, it and the operands stay stable until req_ready.
//   The block does not check this rule.
//  rr_ptr wraps mod N_REQ. Non-power-of-2 N_REQ: pointer values >= N_REQ never occur.
//  resp_z/resp_status are bit-identical to fp_mult #(round) for the same a,b. No extra flag logic.
//  Simultaneous events: a request arriving while in RESP with resp_ready=1 is granted the following cycle (IDLE).
//  Reset in CALC or RESP discards the operation. No resp_valid for it after reset release.
// STRUCTURE
//  fp_mult_pkg (shared): round_values enum (existing), typedef enum logic[1:0] {IDLE,CALC,RESP} arb_state_t,
//   localparam FP_W=32, STATUS_W=8.
//  Sub-module rr_arbiter #(N): inputs req[N], ptr; outputs gnt[N] one-hot and gnt_idx. Combinational.
//  fp_mult #(round) instantiated once, fed only from the operand registers.
// TESTING (compare every response against multiplication(round.name, a, b))
//  1 Single req: req0 a=0x40000000 (2.0), b=0x40400000 (3.0) -> req_ready[0] cycle 0;
//    resp_valid cycle 2, resp_id=0, resp_z=0x40C00000.
//  2 Contention: req0 and req2 valid together, rr_ptr=0 -> req0 granted first, req2 next.
//    rr_ptr=3 after the second grant; resp_id order 0,2.
//  3 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_* stable, req_ready all 0.
//    Accept on the 6th cycle -> IDLE, then the next grant.
//  4 Fairness: all 4 valid continuously for 12 grants -> grant order 0,1,2,3,0,1,2,3,...
//  5 Reset mid-op: assert rst asynchronously in CALC -> outputs 0 immediately, no stale response afterwards.
//    A fresh req1 1.5*2.0 (0x3FC00000, 0x40000000) -> resp_z=0x40400000, resp_id=1.
//  6 Specials via req3: inf*0 (0x7F800000, 0x00000000) and max*max -> z/status identical to a standalone fp_mult.

Source files
------------

// File: rtl/fp_mult_pkg.sv
// ----------------------------------------------------------------------------
// fp_mult_pkg
// Shared types and constants for the single-precision multiplier and the
// arbiter that shares it between several requesters.
//   round_values : rounding modes understood by fp_mult
//   arb_state_t  : arbiter FSM states
//   FP_W         : operand / product width (IEEE-754 single)
//   STATUS_W     : width of the multiplier status vector
//   ST_*         : bit positions inside the status vector
// ----------------------------------------------------------------------------
package fp_mult_pkg;

   typedef enum logic [1:0] {
      IEEE_near    = 2'd0,
      IEEE_zero    = 2'd1,
      IEEE_pos_inf = 2'd2,
      IEEE_neg_inf = 2'd3
   } round_values;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam int FP_W     = 32;
   localparam int STATUS_W = 8;

   localparam int ST_ZERO    = 0;
   localparam int ST_INF     = 1;
   localparam int ST_INVALID = 2;
   localparam int ST_TINY    = 3;
   localparam int ST_HUGE    = 4;
   localparam int ST_INEXACT = 5;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fp_mult.sv
// ----------------------------------------------------------------------------
// fp_mult
// Combinational IEEE-754 single-precision multiplier with selectable rounding.
// Subnormal inputs and outputs are handled; NaN results are the canonical
// quiet NaN.
//   a, b   in  32  operands
//   z      out 32  product
//   status out 8   {2'b0, inexact, huge, tiny, invalid, infinity, zero}
// ----------------------------------------------------------------------------
module fp_mult
   import fp_mult_pkg::*;
#(
   parameter round_values round = IEEE_near
) (
   input  logic [FP_W-1:0]     a,
   input  logic [FP_W-1:0]     b,
   output logic [FP_W-1:0]     z,
   output logic [STATUS_W-1:0] status
);

   logic               sign;
   logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic [7:0]         exp_a, exp_b;
   logic [23:0]        sig_a, sig_b;
   logic [47:0]        prod, norm_pre, norm;
   logic [5:0]         lead, shift;
   logic signed [11:0] exp_pre, exp_fin;
   logic [11:0]        rsh;
   logic               tiny, lost, guard, sticky, inc, to_inf;
   logic [24:0]        rounded;
   logic [22:0]        mant;

   assign sign   = a[31] ^ b[31];
   assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
   assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
   assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
   assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
   assign a_zero = (a[30:0] == 31'd0);
   assign b_zero = (b[30:0] == 31'd0);

   // Subnormals carry no hidden bit and use the minimum exponent of 1.
   assign exp_a = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
   assign exp_b = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
   assign sig_a = {a[30:23] != 8'd0, a[22:0]};
   assign sig_b = {b[30:23] != 8'd0, b[22:0]};
   assign prod  = sig_a * sig_b;

   // Normalise so the leading one sits at bit 47, then, when the exponent
   // falls below the normal range, shift back right into subnormal form while
   // collecting the discarded bits into a sticky flag. The biased exponent of
   // the value norm[47].norm[46:0] is exp_a + exp_b - 126 - shift.
   always_comb begin
      lead = '0;
      for (int i = 0; i < 48; i++) begin
         if (prod[i]) begin
            lead = 6'(i);
         end
      end
      shift    = 6'd47 - lead;
      norm_pre = prod << shift;
      exp_pre  = $signed({4'b0, exp_a}) + $signed({4'b0, exp_b})
                 - 12'sd126 - $signed({6'b0, shift});
      tiny = 1'b0;
      lost = 1'b0;
      rsh  = '0;
      norm = norm_pre;
      if (exp_pre <= 12'sd0) begin
         tiny = 1'b1;
         rsh  = 12'sd1 - exp_pre;
         if (rsh >= 12'd48) begin
            norm = '0;
            lost = |norm_pre;
         end else begin
            norm = norm_pre >> rsh;
            lost = |(norm_pre & ~(48'hFFFF_FFFF_FFFF << rsh));
         end
      end
   end

   // Round at bit 24. A carry out of the significand bumps the exponent; for
   // subnormals a carry into the hidden position makes the result the
   // smallest normal number.
   always_comb begin
      guard  = norm[23];
      sticky = (|norm[22:0]) | lost;
      inc    = 1'b0;
      to_inf = 1'b1;
      case (round)
         IEEE_near: begin
            inc    = guard & (sticky | norm[24]);
            to_inf = 1'b1;
         end
         IEEE_zero: begin
            inc    = 1'b0;
            to_inf = 1'b0;
         end
         IEEE_pos_inf: begin
            inc    = ~sign & (guard | sticky);
            to_inf = ~sign;
         end
         IEEE_neg_inf: begin
            inc    = sign & (guard | sticky);
            to_inf = sign;
         end
      endcase
      rounded = {1'b0, norm[47:24]} + {24'd0, inc};
      if (tiny) begin
         exp_fin = {11'd0, rounded[23]};
      end else begin
         exp_fin = exp_pre + $signed({11'd0, rounded[24]});
      end
      mant = rounded[24] ? rounded[23:1] : rounded[22:0];
   end

   // Special operands take priority over the arithmetic path, then overflow.
   always_comb begin
      status = '0;
      if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
         z                  = QNAN;
         status[ST_INVALID] = 1'b1;
      end else if (a_inf || b_inf) begin
         z              = {sign, 8'hFF, 23'd0};
         status[ST_INF] = 1'b1;
      end else if (a_zero || b_zero) begin
         z               = {sign, 31'd0};
         status[ST_ZERO] = 1'b1;
      end else if (exp_fin >= 12'sd255) begin
         z                  = to_inf ? {sign, 8'hFF, 23'd0} : {sign, 8'hFE, 23'h7FFFFF};
         status[ST_INF]     = to_inf;
         status[ST_HUGE]    = 1'b1;
         status[ST_INEXACT] = 1'b1;
      end else begin
         z                  = {sign, exp_fin[7:0], mant};
         status[ST_ZERO]    = (exp_fin == 12'sd0) && (mant == 23'd0);
         status[ST_TINY]    = tiny;
         status[ST_INEXACT] = guard | sticky;
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The search starts at ptr and walks
// upwards, wrapping from N-1 back to 0; the first asserted request wins.
//   req     in  N      request vector
//   ptr     in  IDX_W  index with the highest priority this cycle
//   gnt     out N      one-hot grant, zero when nothing is requested
//   gnt_idx out IDX_W  index of the granted request (0 when none)
// ----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N = 4,
   localparam int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   int               cand;
   logic [IDX_W-1:0] cand_idx;
   logic             found;

   // Visit the requesters in priority order starting at ptr; the found flag
   // keeps later candidates from overriding the first winner.
   always_comb begin
      gnt      = '0;
      gnt_idx  = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int i = 0; i < N; i++) begin
         cand = int'(ptr) + i;
         if (cand >= N) begin
            cand = cand - N;
         end
         cand_idx = IDX_W'(cand);
         if (!found && req[cand_idx]) begin
            found         = 1'b1;
            gnt[cand_idx] = 1'b1;
            gnt_idx       = cand_idx;
         end
      end
   end

endmodule

// File: rtl/fp_mult_arbiter.sv
// ----------------------------------------------------------------------------
// fp_mult_arbiter
// Shares one combinational fp_mult between N_REQ requesters. A round-robin
// arbiter picks one requester, its operands are registered, the product is
// captured one cycle later and held on the response port until accepted.
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   req_valid    in  N_REQ        per-requester operand valid
//   req_ready    out N_REQ        per-requester grant, one-hot or zero
//   req_a, req_b in  N_REQ*32     per-requester operands, requester i at [32i +: 32]
//   resp_valid   out 1            result available
//   resp_ready   in  1            consumer accepts the result
//   resp_id      out ID_W         requester that issued the result
//   resp_z       out 32           product
//   resp_status  out 8            multiplier status for the product
//   busy         out 1            high while an operation is in flight
// ----------------------------------------------------------------------------
module fp_mult_arbiter
   import fp_mult_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter round_values round = IEEE_near,
   localparam int ID_W = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*FP_W-1:0]   req_a,
   input  logic [N_REQ*FP_W-1:0]   req_b,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [ID_W-1:0]         resp_id,
   output logic [FP_W-1:0]         resp_z,
   output logic [STATUS_W-1:0]     resp_status,
   output logic                    busy
);

   arb_state_t          state;
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     win_idx;
   logic [ID_W-1:0]     op_id;
   logic [N_REQ-1:0]    gnt;
   logic [FP_W-1:0]     sel_a, sel_b;
   logic [FP_W-1:0]     op_a, op_b;
   logic [FP_W-1:0]     mult_z;
   logic [STATUS_W-1:0] mult_status;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req     (req_valid),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (win_idx)
   );

   fp_mult #(.round(round)) u_mult (
      .a      (op_a),
      .b      (op_b),
      .z      (mult_z),
      .status (mult_status)
   );

   // Grants are only offered while idle, and never while reset is applied.
   assign req_ready = (state == IDLE && !rst) ? gnt : '0;
   assign resp_id   = op_id;

   // The grant is one-hot, so OR-ing the granted lanes selects the winner.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            sel_a = sel_a | req_a[i*FP_W +: FP_W];
            sel_b = sel_b | req_b[i*FP_W +: FP_W];
         end
      end
   end

   // Three-phase controller: grant and register operands, capture the
   // product, then hold the response. The pointer moves past the winner so a
   // persistently requesting client waits at most N_REQ-1 other grants.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         op_a        <= '0;
         op_b        <= '0;
         op_id       <= '0;
         resp_z      <= '0;
         resp_status <= '0;
         resp_valid  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  op_a   <= sel_a;
                  op_b   <= sel_b;
                  op_id  <= win_idx;
                  rr_ptr <= (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
                  state  <= CALC;
                  busy   <= 1'b1;
               end
            end
            CALC: begin
               resp_z      <= mult_z;
               resp_status <= mult_status;
               resp_valid  <= 1'b1;
               state       <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               resp_valid <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule
